// File: rtl/game_over_pkg.sv
// -----------------------------------------------------------------------------
// game_over_pkg
// Shared types and constants for the "GAME OVER" overlay renderer:
//   - state_t     : overlay control FSM states
//   - glyph_id_t  : identifiers of the glyphs used by the two text rows
//   - rgb12_t     : packed {r,g,b} colour, 4 bits per channel
//   - FONT_*      : 5x5 font bitmaps, row 0 in bits [24:20], bit 4 of a row
//                   is the leftmost cell
//   - ROW0_STR / ROW1_STR : glyph strings for the "GAME" and "OVER" rows
// -----------------------------------------------------------------------------
package game_over_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ARMED,
    ST_SHOW,
    ST_WAIT_RST,
    ST_LEAVING
  } state_t;

  typedef enum logic [2:0] {
    GLYPH_G,
    GLYPH_A,
    GLYPH_M,
    GLYPH_E,
    GLYPH_O,
    GLYPH_V,
    GLYPH_R
  } glyph_id_t;

  typedef logic [11:0] rgb12_t;

  // Glyphs are GLYPH_SIZE cells square and placed on a GLYPH_PITCH-cell pitch,
  // so the last cell column of every pitch slot is an inter-glyph gap.
  localparam int GLYPH_SIZE  = 5;
  localparam int GLYPH_PITCH = 6;
  localparam int GLYPHS_ROW  = 4;
  localparam int TEXT_COLS   = GLYPH_PITCH * GLYPHS_ROW;

  localparam logic [24:0] FONT_G = {5'b11111, 5'b10000, 5'b10111, 5'b10001, 5'b11111};
  localparam logic [24:0] FONT_A = {5'b01110, 5'b10001, 5'b11111, 5'b10001, 5'b10001};
  localparam logic [24:0] FONT_M = {5'b10001, 5'b11011, 5'b10101, 5'b10001, 5'b10001};
  localparam logic [24:0] FONT_E = {5'b11111, 5'b10000, 5'b11110, 5'b10000, 5'b11111};
  localparam logic [24:0] FONT_O = {5'b01110, 5'b10001, 5'b10001, 5'b10001, 5'b01110};
  localparam logic [24:0] FONT_V = {5'b10001, 5'b10001, 5'b10001, 5'b01010, 5'b00100};
  localparam logic [24:0] FONT_R = {5'b11110, 5'b10001, 5'b11110, 5'b10100, 5'b10010};

  localparam glyph_id_t ROW0_STR [GLYPHS_ROW] = '{GLYPH_G, GLYPH_A, GLYPH_M, GLYPH_E};
  localparam glyph_id_t ROW1_STR [GLYPHS_ROW] = '{GLYPH_O, GLYPH_V, GLYPH_E, GLYPH_R};

  // Picks the glyph at position idx of the selected text row (0 = GAME, 1 = OVER).
  function automatic glyph_id_t rowGlyph(input logic rowSel, input logic [1:0] idx);
    return rowSel ? ROW1_STR[idx] : ROW0_STR[idx];
  endfunction

endpackage

// File: rtl/game_over_screen_glyph_rom.sv
// -----------------------------------------------------------------------------
// glyph_rom
// Combinational 5x5 font lookup.
//   i_glyph : glyph identifier
//   i_row   : cell row inside the glyph (0 = top); rows >= 5 give 0
//   i_col   : cell column inside the glyph (0 = left); columns >= 5 give 0,
//             which covers the inter-glyph gap column
//   o_bit   : 1 when the addressed cell is lit
// -----------------------------------------------------------------------------
module glyph_rom
  import game_over_pkg::*;
(
  input  glyph_id_t  i_glyph,
  input  logic [2:0] i_row,
  input  logic [2:0] i_col,
  output logic       o_bit
);

  logic [24:0] w_font;
  logic [4:0]  w_bitIdx;
  logic        w_inCell;

  // Select the bitmap, then address it MSB-first: row r, column c lives at
  // bit 24 - 5r - c. Out-of-glyph addresses are masked rather than indexed.
  always_comb begin
    w_font = '0;
    case (i_glyph)
      GLYPH_G: w_font = FONT_G;
      GLYPH_A: w_font = FONT_A;
      GLYPH_M: w_font = FONT_M;
      GLYPH_E: w_font = FONT_E;
      GLYPH_O: w_font = FONT_O;
      GLYPH_V: w_font = FONT_V;
      GLYPH_R: w_font = FONT_R;
      default: w_font = '0;
    endcase
    w_inCell = (i_row < 3'(GLYPH_SIZE)) && (i_col < 3'(GLYPH_SIZE));
    w_bitIdx = 5'(GLYPH_SIZE * GLYPH_SIZE - 1) - (5'(i_row) * 5'(GLYPH_SIZE)) - 5'(i_col);
    o_bit    = w_inCell ? w_font[w_bitIdx] : 1'b0;
  end

endmodule

// File: rtl/game_over_screen.sv
// -----------------------------------------------------------------------------
// game_over_screen
// Frame-synchronous "GAME OVER" overlay. A collision arms the overlay, which
// turns on at the next frame start, blinks the text, holds for HOLD_FRAMES
// frames and then waits for a restart, turning off again at a frame start.
// Ports:
//   clk_d     : pixel clock, one (x,y) per cycle
//   rst       : asynchronous active-high reset
//   x, y      : current pixel coordinates
//   video_on  : visible-area qualifier
//   collision : collision indication (level or pulse)
//   restart   : synchronised restart request (level)
//   red/green/blue : registered colour, 2 cycles after (x, y, video_on)
//   active    : overlay owns the screen
// -----------------------------------------------------------------------------
module game_over_screen
  import game_over_pkg::*;
#(
  parameter int     H_ACTIVE     = 640,
  parameter int     V_ACTIVE     = 480,
  parameter int     BORDER       = 40,
  parameter int     CELL_LOG2    = 4,
  parameter int     TEXT_X0      = 128,
  parameter int     ROW0_Y       = 120,
  parameter int     ROW1_Y       = 260,
  parameter int     BLINK_FRAMES = 30,
  parameter int     HOLD_FRAMES  = 120,
  parameter rgb12_t TEXT_RGB     = 12'hF0F,
  parameter rgb12_t BG_RGB       = 12'hFFF,
  parameter rgb12_t BORDER_RGB   = 12'h010
) (
  input  logic       clk_d,
  input  logic       rst,
  input  logic [9:0] x,
  input  logic [9:0] y,
  input  logic       video_on,
  input  logic       collision,
  input  logic       restart,
  output logic [3:0] red,
  output logic [3:0] green,
  output logic [3:0] blue,
  output logic       active
);

  localparam int CNT_SRC = (HOLD_FRAMES > BLINK_FRAMES) ? HOLD_FRAMES : BLINK_FRAMES;
  localparam int CNT_W   = (CNT_SRC < 1) ? 1 : $clog2(CNT_SRC + 1);
  localparam logic [CNT_W-1:0] CNT_SAT = '1;

  localparam logic [10:0] BORDER_L = 11'(BORDER);
  localparam logic [10:0] BORDER_R = 11'(H_ACTIVE - BORDER);
  localparam logic [10:0] BORDER_T = 11'(BORDER);
  localparam logic [10:0] BORDER_B = 11'(V_ACTIVE - BORDER);
  localparam logic [10:0] TEXT_XL  = 11'(TEXT_X0);
  localparam logic [10:0] TEXT_XR  = 11'(TEXT_X0 + (TEXT_COLS << CELL_LOG2));
  localparam logic [10:0] ROW0_YT  = 11'(ROW0_Y);
  localparam logic [10:0] ROW0_YB  = 11'(ROW0_Y + (GLYPH_SIZE << CELL_LOG2));
  localparam logic [10:0] ROW1_YT  = 11'(ROW1_Y);
  localparam logic [10:0] ROW1_YB  = 11'(ROW1_Y + (GLYPH_SIZE << CELL_LOG2));

  state_t           r_state;
  state_t           w_stateNext;
  logic             w_enterShow;
  logic             r_active;
  logic [9:0]       r_yQ;
  logic             w_fs;
  logic [CNT_W-1:0] r_frameCnt;
  logic [CNT_W-1:0] r_blinkCnt;
  logic             r_blinkPhase;
  logic             w_holdDone;
  logic             w_blinkWrap;
  logic             w_blinkRun;

  // Stage-1 combinational geometry
  logic [10:0] w_x11;
  logic [10:0] w_y11;
  logic        w_border;
  logic        w_inCols;
  logic        w_inRow0;
  logic        w_inRow1;
  logic [9:0]  w_dx;
  logic [9:0]  w_dy;
  logic [4:0]  w_col;
  logic [4:0]  w_colBase;
  logic [1:0]  w_glyphIdx;
  logic [2:0]  w_cellRow;
  logic [2:0]  w_cellCol;

  // Stage-1 registers
  logic       r_s1Video;
  logic       r_s1Border;
  logic       r_s1Text;
  logic       r_s1RowSel;
  logic [1:0] r_s1Glyph;
  logic [2:0] r_s1CellRow;
  logic [2:0] r_s1CellCol;

  // Stage-2
  glyph_id_t w_glyphId;
  logic      w_romBit;
  rgb12_t    w_rgbNext;
  rgb12_t    r_rgb;

  // A frame starts on the single cycle where y drops back to 0.
  assign w_fs = (r_yQ != 10'd0) && (y == 10'd0);

  assign w_holdDone  = (int'(r_frameCnt) + 1) >= HOLD_FRAMES;
  assign w_blinkWrap = (BLINK_FRAMES != 0) && (int'(r_blinkCnt) == BLINK_FRAMES - 1);
  assign w_blinkRun  = (r_state == ST_SHOW) || (r_state == ST_WAIT_RST);

  // Remember the previous row so the frame-start edge can be detected.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_yQ <= '0;
    end else begin
      r_yQ <= y;
    end
  end

  // Overlay control state register; active follows the next state so it
  // changes in the same edge that the FSM leaves or enters the visible states.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_active <= 1'b0;
    end else begin
      r_state  <= w_stateNext;
      r_active <= (w_stateNext == ST_SHOW) || (w_stateNext == ST_WAIT_RST) ||
                  (w_stateNext == ST_LEAVING);
    end
  end

  // Next-state logic. Every visibility change waits for a frame start so the
  // overlay never tears; restart is checked before anything else in WAIT_RST,
  // so a simultaneous collision is simply dropped.
  always_comb begin
    w_stateNext = r_state;
    w_enterShow = 1'b0;
    case (r_state)
      ST_IDLE:     if (collision) w_stateNext = ST_ARMED;
      ST_ARMED: begin
        if (w_fs) begin
          w_stateNext = ST_SHOW;
          w_enterShow = 1'b1;
        end
      end
      ST_SHOW:     if (w_fs && w_holdDone) w_stateNext = ST_WAIT_RST;
      ST_WAIT_RST: if (restart) w_stateNext = ST_LEAVING;
      ST_LEAVING:  if (w_fs) w_stateNext = ST_IDLE;
      default:     w_stateNext = ST_IDLE;
    endcase
  end

  // Frame and blink counters. Both saturate instead of wrapping; the blink
  // phase only toggles when a non-zero blink period elapses.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_frameCnt   <= '0;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else if (w_enterShow) begin
      r_frameCnt   <= '0;
      r_blinkCnt   <= '0;
      r_blinkPhase <= 1'b0;
    end else begin
      if ((r_state == ST_SHOW) && w_fs && (r_frameCnt != CNT_SAT)) begin
        r_frameCnt <= r_frameCnt + 1'b1;
      end
      if (w_blinkRun && w_fs) begin
        if (w_blinkWrap) begin
          r_blinkPhase <= ~r_blinkPhase;
          r_blinkCnt   <= '0;
        end else if (r_blinkCnt != CNT_SAT) begin
          r_blinkCnt <= r_blinkCnt + 1'b1;
        end
      end
    end
  end

  // Stage-1 geometry: border test, text-window range checks and the mapping
  // of (x, y) to glyph index and cell position. The range checks come first
  // so the 10-bit subtractions are only trusted where they cannot underflow.
  always_comb begin
    w_x11    = {1'b0, x};
    w_y11    = {1'b0, y};
    w_border = (w_x11 < BORDER_L) || (w_x11 >= BORDER_R) ||
               (w_y11 < BORDER_T) || (w_y11 >= BORDER_B);
    w_inCols = (w_x11 >= TEXT_XL) && (w_x11 < TEXT_XR);
    w_inRow0 = w_inCols && (w_y11 >= ROW0_YT) && (w_y11 < ROW0_YB);
    w_inRow1 = w_inCols && !w_inRow0 && (w_y11 >= ROW1_YT) && (w_y11 < ROW1_YB);
    w_dx     = x - 10'(TEXT_X0);
    w_dy     = y - (w_inRow0 ? 10'(ROW0_Y) : 10'(ROW1_Y));
    w_col    = 5'(w_dx >> CELL_LOG2);
    w_cellRow = 3'(w_dy >> CELL_LOG2);
    if (w_col < 5'(GLYPH_PITCH)) begin
      w_glyphIdx = 2'd0;
      w_colBase  = 5'd0;
    end else if (w_col < 5'(2 * GLYPH_PITCH)) begin
      w_glyphIdx = 2'd1;
      w_colBase  = 5'(GLYPH_PITCH);
    end else if (w_col < 5'(3 * GLYPH_PITCH)) begin
      w_glyphIdx = 2'd2;
      w_colBase  = 5'(2 * GLYPH_PITCH);
    end else begin
      w_glyphIdx = 2'd3;
      w_colBase  = 5'(3 * GLYPH_PITCH);
    end
    w_cellCol = 3'(w_col - w_colBase);
  end

  // Stage-1 pipeline registers.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_s1Video   <= 1'b0;
      r_s1Border  <= 1'b0;
      r_s1Text    <= 1'b0;
      r_s1RowSel  <= 1'b0;
      r_s1Glyph   <= '0;
      r_s1CellRow <= '0;
      r_s1CellCol <= '0;
    end else begin
      r_s1Video   <= video_on;
      r_s1Border  <= w_border;
      r_s1Text    <= w_inRow0 || w_inRow1;
      r_s1RowSel  <= w_inRow1;
      r_s1Glyph   <= w_glyphIdx;
      r_s1CellRow <= w_cellRow;
      r_s1CellCol <= w_cellCol;
    end
  end

  assign w_glyphId = rowGlyph(r_s1RowSel, r_s1Glyph);

  glyph_rom u_glyphRom (
    .i_glyph (w_glyphId),
    .i_row   (r_s1CellRow),
    .i_col   (r_s1CellCol),
    .o_bit   (w_romBit)
  );

  // Stage-2 colour priority. The live active flag is used here so the first
  // pixel after a frame start already reflects the new overlay state.
  always_comb begin
    w_rgbNext = '0;
    if (!r_s1Video || !r_active) begin
      w_rgbNext = '0;
    end else if (r_s1Border) begin
      w_rgbNext = BORDER_RGB;
    end else if (r_s1Text && w_romBit && !r_blinkPhase) begin
      w_rgbNext = TEXT_RGB;
    end else begin
      w_rgbNext = BG_RGB;
    end
  end

  // Stage-2 colour register.
  always_ff @(posedge clk_d or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= w_rgbNext;
    end
  end

  assign red    = r_rgb[11:8];
  assign green  = r_rgb[7:4];
  assign blue   = r_rgb[3:0];
  assign active = r_active;

endmodule
